fifo_wr_arbiter: RTL and testbench

- Shares the single write port of one fifo_sync instance between NUM_REQ independent producers.
- Uses round-robin arbitration with bounded bursts: a granted producer holds the port for up to MAX_BURST beats, then priority rotates.
- Drives the FIFO's cs, wr_en and data_in and honours its full flag.
- The read side of the FIFO is not touched by this block.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_sync.sv | 55 +++++
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO write-side arbiter and its FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DATA_WIDTH = 32;

    // Arbiter ownership state: nobody granted, or grant_id owns the FIFO port.
    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with show-ahead read data; cs gates the write port only.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_sync #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  do_wr, do_rd;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_wr    = cs & wr_en & ~full;
    assign do_rd    = rd_en & ~empty;
    assign data_out = mem[rd_ptr_q];

    // Storage array; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin selector: first set bit of req scanning upward from start, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan NUM_REQ positions from start; the first hit wins.
    always_comb begin
        int unsigned pos;
        pos = 0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(start) + k) % NUM_REQ;
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    import fifo_pkg::*;

    localparam int unsigned       BeatW    = $clog2(MAX_BURST) + 1;
    localparam logic [BeatW-1:0]  LastBeat = BeatW'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LastId   = ID_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [ID_W-1:0]    next_id, pick_start, pick_idx;
    logic [NUM_REQ-1:0] pick_req, grant_oh;
    logic               pick_any, owner_valid, burst_done;

    assign next_id     = (grant_q == LastId) ? '0 : grant_q + 1'b1;
    assign grant_oh    = NUM_REQ'(1) << grant_q;
    assign owner_valid = req_valid[grant_q];
    assign grant_id    = grant_q;

    // Write strobe and data mux, all from the registered grant.
    always_comb begin
        busy         = (state_q == StGrant);
        fifo_wr_en   = busy & owner_valid & ~fifo_full;
        fifo_cs      = fifo_wr_en;
        req_ready    = fifo_wr_en ? grant_oh : '0;
        fifo_data_in = busy ? req_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        burst_done   = fifo_wr_en && (beat_q == LastBeat);
    end

    // Arbiter candidates: a producer ending a full burst sits out the immediate re-pick.
    always_comb begin
        pick_req   = req_valid;
        pick_start = rr_ptr_q;
        if (busy) begin
            pick_req   = req_valid & ~(burst_done ? grant_oh : '0);
            pick_start = next_id;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (pick_req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state: grant, burst counting, release and back-to-back hand-over.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StGrant;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            StGrant: begin
                if (burst_done || !owner_valid) begin
                    rr_ptr_d = next_id;
                    beat_d   = '0;
                    if (pick_any) begin
                        grant_d = pick_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (fifo_wr_en) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any in-flight word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned MB    = 4;
    localparam int unsigned DEPTH = fifo_pkg::FIFO_DEPTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_cs, fifo_wr_en, fifo_full, fifo_empty, rd_en;
    logic [DW-1:0]     fifo_data_in, fifo_data_out;
    logic [1:0]        grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_cs      (fifo_cs),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    fifo_sync #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (fifo_cs),
        .wr_en    (fifo_wr_en),
        .rd_en    (rd_en),
        .data_in  (fifo_data_in),
        .data_out (fifo_data_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: producer word queues, FIFO contents, and who owns the port.
    logic [DW-1:0] pq [N][$];
    logic [DW-1:0] fq [$];
    logic [DW-1:0] rdq [$];
    int            xfer_owner [$];
    logic [N-1:0]  gate;
    bit            m_busy;
    int            m_gid, m_ptr, m_beats, wr_pulses;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_valid(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = gate[i] && (pq[i].size() > 0);
            req_data[i*DW +: DW]  = (pq[i].size() > 0) ? pq[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_gid   = 0;
        m_ptr   = 0;
        m_beats = 0;
        fq.delete();
    endtask

    // One clock: present inputs, compare at the falling edge, advance the model.
    task automatic step();
        bit            exp_wr, rd_ok, done_burst, dropped;
        logic [N-1:0]  exp_rdy, others;
        logic [DW-1:0] exp_data;
        drive();
        @(negedge clk);
        exp_wr   = m_busy && req_valid[m_gid] && (fq.size() < DEPTH);
        exp_rdy  = exp_wr ? (N'(1) << m_gid) : '0;
        exp_data = (m_busy && pq[m_gid].size() > 0) ? pq[m_gid][0] : '0;
        check("busy", DW'(busy), DW'(m_busy));
        check("grant_id", DW'(grant_id), DW'(m_gid));
        check("wr_en", DW'(fifo_wr_en), DW'(exp_wr));
        check("cs", DW'(fifo_cs), DW'(exp_wr));
        check("req_ready", DW'(req_ready), DW'(exp_rdy));
        check("data_in", fifo_data_in, exp_data);
        check("full", DW'(fifo_full), DW'(fq.size() == DEPTH));
        check("empty", DW'(fifo_empty), DW'(fq.size() == 0));
        rd_ok = rd_en && (fq.size() > 0);
        if (rd_ok) begin
            check("data_out", fifo_data_out, fq[0]);
            rdq.push_back(fifo_data_out);
        end
        if (fifo_wr_en) begin
            wr_pulses++;
            xfer_owner.push_back(int'(grant_id));
        end
        if (rd_ok) void'(fq.pop_front());
        if (exp_wr) fq.push_back(pq[m_gid].pop_front());
        if (!m_busy) begin
            if (|req_valid) begin
                m_busy  = 1'b1;
                m_gid   = first_valid(req_valid, m_ptr);
                m_beats = 0;
            end
        end else begin
            done_burst = exp_wr && (m_beats == MB - 1);
            dropped    = !req_valid[m_gid];
            if (done_burst || dropped) begin
                others = req_valid;
                if (done_burst) others[m_gid] = 1'b0;
                m_ptr   = (m_gid + 1) % N;
                m_beats = 0;
                if (|others) m_gid = first_valid(others, m_ptr);
                else         m_busy = 1'b0;
            end else if (exp_wr) begin
                m_beats++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive();
        rst_n = 1'b0;
        #1;
        check("rst_busy", DW'(busy), 0);
        check("rst_wr_en", DW'(fifo_wr_en), 0);
        check("rst_ready", DW'(req_ready), 0);
        check("rst_grant", DW'(grant_id), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_lists();
        rdq.delete();
        xfer_owner.delete();
        wr_pulses = 0;
    endtask

    initial begin
        logic [DW-1:0] v;
        int            k4;
        rst_n     = 1'b0;
        rd_en     = 1'b0;
        gate      = '1;
        req_valid = '1;
        req_data  = '0;
        model_reset();
        clear_lists();

        // Reset with every producer requesting.
        #2;
        check("reset_busy", DW'(busy), 0);
        check("reset_wr_en", DW'(fifo_wr_en), 0);
        check("reset_cs", DW'(fifo_cs), 0);
        check("reset_ready", DW'(req_ready), 0);
        check("reset_grant", DW'(grant_id), 0);
        check("reset_data", fifo_data_in, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single producer 2 sends 1 then 10.
        clear_lists();
        pq[2].push_back(32'd1);
        pq[2].push_back(32'd10);
        step();
        check("single_grant", DW'(grant_id), 2);
        for (int i = 0; i < 5; i++) step();
        check("single_pulses", DW'(wr_pulses), 2);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rd_en = 1'b0;
        check("single_rd_cnt", DW'(rdq.size()), 2);
        if (rdq.size() == 2) begin
            check("single_rd0", rdq[0], 32'd1);
            check("single_rd1", rdq[1], 32'd10);
        end

        // Rotation: all four continuously valid, producer i sends i*16+n.
        do_reset();
        clear_lists();
        for (int i = 0; i < N; i++)
            for (int n = 0; n < 8; n++) pq[i].push_back(DW'(i * 16 + n));
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) step();
        rd_en = 1'b0;
        check("rot_xfers", DW'(xfer_owner.size()), 32);
        check("rot_reads", DW'(rdq.size()), 32);
        for (int k = 0; k < 32; k++) begin
            k4 = (k / 4) % 4;
            if (k < xfer_owner.size()) check("rot_owner", DW'(xfer_owner[k]), DW'(k4));
            if (k < rdq.size()) check("rot_data", rdq[k], DW'(k4 * 16 + (k / 16) * 4 + k % 4));
        end

        // Full stall: producer 1 streams powers of two into a non-draining FIFO.
        do_reset();
        clear_lists();
        for (int k = 0; k < 10; k++) pq[1].push_back(DW'(1) << k);
        for (int i = 0; i < 14; i++) step();
        check("full_flag", DW'(fifo_full), 1);
        check("full_wr_en", DW'(fifo_wr_en), 0);
        check("full_ready", DW'(req_ready), 0);
        check("full_grant", DW'(grant_id), 1);
        check("full_busy", DW'(busy), 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("unfull_wr_en", DW'(fifo_wr_en), 1);
        check("unfull_data", fifo_data_in, 32'd256);
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rd_en = 1'b0;
        check("full_rd_cnt", DW'(rdq.size()), 10);
        for (int k = 0; k < 10; k++)
            if (k < rdq.size()) check("full_rd", rdq[k], DW'(1) << k);

        // Early drop: producer 0 runs dry after 2 beats while 1 and 3 wait.
        do_reset();
        clear_lists();
        pq[0].push_back(32'hA0); pq[0].push_back(32'hA1);
        for (int n = 0; n < 3; n++) begin
            pq[1].push_back(DW'(32'hB0 + n));
            pq[3].push_back(DW'(32'hD0 + n));
        end
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) step();
        rd_en = 1'b0;
        check("drop_xfers", DW'(xfer_owner.size()), 8);
        check("drop_reads", DW'(rdq.size()), 8);
        for (int k = 0; k < 8; k++) begin
            k4 = (k < 2) ? 0 : (k < 5) ? 1 : 3;
            v  = (k < 2) ? DW'(32'hA0 + k) : (k < 5) ? DW'(32'hB0 + k - 2) : DW'(32'hD0 + k - 5);
            if (k < xfer_owner.size()) check("drop_owner", DW'(xfer_owner[k]), DW'(k4));
            if (k < rdq.size()) check("drop_data", rdq[k], v);
        end

        // Reset in the middle of producer 2's second beat.
        do_reset();
        clear_lists();
        for (int n = 0; n < 6; n++) pq[2].push_back(DW'(32'hC0 + n));
        step();
        step();
        drive();
        #1;
        check("mid_wr_before", DW'(fifo_wr_en), 1);
        rst_n = 1'b0;
        #1;
        check("mid_wr_after", DW'(fifo_wr_en), 0);
        check("mid_cs_after", DW'(fifo_cs), 0);
        check("mid_busy_after", DW'(busy), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pq[0].push_back(32'hE0);
        step();
        check("mid_regrant", DW'(grant_id), 0);
        rd_en = 1'b1;
        for (int i = 0; i < 12; i++) step();

        // Random traffic with random valid gating and reads.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (pq[i].size() < 3 && $urandom_range(0, 3) == 0) pq[i].push_back($urandom);
            gate  = N'($urandom);
            rd_en = ($urandom_range(0, 1) == 1);
            step();
        end
        gate  = '1;
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("final_empty", DW'(fifo_empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
